// File: rtl/fpadd_issue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fpadd_issue: operand FIFO, start/done launcher and valid/ready result      |
// | register in front of a multicycle floating-point adder.                    |
// | Optional macro FPADD_TIMEOUT_EN: abort a hung operation with a quiet NaN.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fpadd_issue #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic        add_start,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic        add_done,
   input  logic [31:0] add_sum,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_sum,
   output logic        out_err
);

   localparam int                 c_PTR_W = $clog2(DEPTH);
   localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);
   localparam logic [31:0]        c_QNAN  = 32'h7FC0_0000;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_param_check
      $error("fpadd_issue: DEPTH must be a power of two >= 2, TIMEOUT >= 2");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_ARM    = 2'd2,
      S_WAIT   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [63:0]          r_mem [DEPTH];
   logic [c_PTR_W-1:0]   r_wr_ptr;
   logic [c_PTR_W-1:0]   r_rd_ptr;
   logic [c_PTR_W:0]     r_count;

   logic                 r_add_start;
   logic [31:0]          r_add_a;
   logic [31:0]          r_add_b;
   logic                 r_out_valid;
   logic [31:0]          r_out_sum;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_capture;
   logic                 w_abort;
   logic [63:0]          w_head;

   assign in_ready  = (r_count != c_FULL);
   assign w_push    = in_valid && in_ready;
   assign w_head    = r_mem[r_rd_ptr];

   assign add_start = r_add_start;
   assign add_a     = r_add_a;
   assign add_b     = r_add_b;
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;

`ifdef FPADD_TIMEOUT_EN
   localparam int                c_TMO_W    = $clog2(TIMEOUT) + 1;
   localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

   logic [c_TMO_W-1:0]   r_tmo;
   logic                 r_out_err;

   // Counter restarts while in ARM so it reads zero on the first WAIT cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tmo     <= '0;
         r_out_err <= 1'b0;
      end else begin
         if (r_state == S_ARM)
            r_tmo <= '0;
         else if (r_state == S_WAIT && !add_done)
            r_tmo <= r_tmo + 1'b1;

         if (w_capture)
            r_out_err <= 1'b0;
         else if (w_abort)
            r_out_err <= 1'b1;
      end
   end

   assign out_err = r_out_err;
`else
   assign out_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // A done seen in ARM is the previous operation's sticky done and is ignored.
   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_capture   = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (r_count != '0 && !r_out_valid) begin
               w_pop       = 1'b1;
               w_state_nxt = S_LAUNCH;
            end
         end
         S_LAUNCH: w_state_nxt = S_ARM;
         S_ARM:    w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (add_done) begin
               w_capture   = 1'b1;
               w_state_nxt = S_IDLE;
            end
`ifdef FPADD_TIMEOUT_EN
            else if (r_tmo == c_TMO_LAST) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
`endif
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {in_a, in_b};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_add_start <= 1'b0;
         r_add_a     <= '0;
         r_add_b     <= '0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
      end else begin
         r_add_start <= w_pop;
         if (w_pop) begin
            r_add_a <= w_head[63:32];
            r_add_b <= w_head[31:0];
         end

         if (w_capture) begin
            r_out_sum   <= add_sum;
            r_out_valid <= 1'b1;
         end else if (w_abort) begin
            r_out_sum   <= c_QNAN;
            r_out_valid <= 1'b1;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fpadd_issue.sv
`default_nettype none
// Scoreboard bench for fpadd_issue: randomized operand pairs, a behavioural
// start/done adder model, and queue-based expectations for issue order and results.
module tb_fpadd_issue;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        add_start;
   logic [31:0] add_a;
   logic [31:0] add_b;
   logic        add_done;
   logic [31:0] add_sum;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_sum;
   logic        out_err;

   fpadd_issue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .add_start (add_start),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_done  (add_done),
      .add_sum   (add_sum),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic [31:0] sum;
   } res_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_issue[$];
   res_t        exp_res[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name, input string what);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got %s", name, what);
   endtask

   // Result the adder model produces; one directed pair returns the true IEEE sum.
   function automatic logic [31:0] sum_fn(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000)
         return 32'h4040_0000;
      return (a ^ {b[30:0], b[31]}) + 32'h9E37_79B9;
   endfunction

   // Adder model: done rises lat_cfg+1 edges after it samples start; sticky until
   // the next start. slow_clear keeps a stale done up for one extra cycle.
   int          lat_cfg    = 2;
   bit          slow_clear = 1'b0;
   bit          hang       = 1'b0;
   logic        mdl_busy;
   logic        mdl_clr;
   int          mdl_cnt;
   logic [31:0] mdl_pend;

   always @(posedge clk) begin
      if (reset) begin
         add_done <= 1'b0;
         add_sum  <= '0;
         mdl_busy <= 1'b0;
         mdl_clr  <= 1'b0;
         mdl_cnt  <= 0;
         mdl_pend <= '0;
      end else if (add_start) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= lat_cfg;
         mdl_pend <= sum_fn(add_a, add_b);
         if (slow_clear) mdl_clr  <= 1'b1;
         else            add_done <= 1'b0;
      end else begin
         if (mdl_clr) begin
            add_done <= 1'b0;
            mdl_clr  <= 1'b0;
         end
         if (mdl_busy && !hang) begin
            if (mdl_cnt == 0) begin
               add_done <= 1'b1;
               add_sum  <= mdl_pend;
               mdl_busy <= 1'b0;
            end else begin
               mdl_cnt <= mdl_cnt - 1;
            end
         end
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit rdy_rand = 1'b0;
   bit rdy_fix  = 1'b1;
   initial forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
   end

   // Monitor: issue order, issue blocking, output hold and result scoreboard.
   int          n_starts  = 0;
   int          start_cyc = 0;
   int          last_lat  = 0;
   logic        prev_hold = 1'b0;
   logic        prev_valid = 1'b0;
   logic [31:0] prev_sum  = '0;

   always @(negedge clk) begin
      logic [63:0] e_ab;
      res_t        e_res;
      if (reset) begin
         prev_hold  <= 1'b0;
         prev_valid <= 1'b0;
      end else begin
         if (add_start) begin
            n_starts  <= n_starts + 1;
            start_cyc <= cyc;
            chk("issue_while_out_valid", out_valid, 0);
            if (exp_issue.size() == 0) begin
               fail_now("unexpected_issue", $sformatf("add_start with a=%h b=%h, required none", add_a, add_b));
            end else begin
               e_ab = exp_issue.pop_front();
               chk("issue_ab", {add_a, add_b}, e_ab);
            end
         end
         if (out_valid && !prev_valid)
            last_lat <= cyc - start_cyc;
         if (out_valid && prev_hold)
            chk("out_sum_hold", out_sum, prev_sum);
         if (out_valid && out_ready) begin
            if (exp_res.size() == 0) begin
               fail_now("unexpected_result", $sformatf("sum=%h, required none", out_sum));
            end else begin
               e_res = exp_res.pop_front();
               chk("result", {out_err, out_sum}, e_res);
            end
         end
         prev_hold  <= out_valid && !out_ready;
         prev_sum   <= out_sum;
         prev_valid <= out_valid;
      end
   end

   int push_cyc = 0;

   task automatic push(input logic [31:0] a, input logic [31:0] b, input bit err_exp);
      int n = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!in_ready) begin
         fail_now("push_wait", "in_ready stuck low, required high");
         in_valid = 1'b0;
         return;
      end
      exp_issue.push_back({a, b});
      exp_res.push_back(err_exp ? res_t'({1'b1, 32'h7FC0_0000}) : res_t'({1'b0, sum_fn(a, b)}));
      @(posedge clk);
      #1;
      push_cyc = cyc;
      in_valid = 1'b0;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_res.size() != 0 || out_valid) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_res.size() != 0 || out_valid) begin
         fail_now("drain", $sformatf("%0d results outstanding, required 0", exp_res.size()));
         exp_res.delete();
         exp_issue.delete();
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int s0;
      int acc;
      int n;
      logic [31:0] a;
      logic [31:0] b;

      // Reset values
      cycles(3);
      reset = 1'b0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_add_start", add_start, 0);
      chk("rst_add_ab", {add_a, add_b}, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_err", out_err, 0);

      // Single directed operation and its timing
      lat_cfg = 10;
      rdy_fix = 1'b1;
      s0 = n_starts;
      push(32'h3F80_0000, 32'h4000_0000, 1'b0);
      drain(200);
      chk("single_start_count", n_starts - s0, 1);
      chk("push_to_start", start_cyc - push_cyc, 1);
      chk("start_to_valid", last_lat, 13);
      chk("out_sum_after_consume", out_sum, 32'h4040_0000);

      // Fill with the adder stalled; accepted pairs cross pointer wrap
      lat_cfg = 60;
      acc = 0;
      for (int i = 0; i < DEPTH + 3; i++) begin
         a = $urandom;
         b = $urandom;
         in_a = a;
         in_b = b;
         in_valid = 1'b1;
         if (in_ready) begin
            acc++;
            exp_issue.push_back({a, b});
            exp_res.push_back(res_t'({1'b0, sum_fn(a, b)}));
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("fill_accepted", acc, DEPTH + 1);
      chk("full_in_ready", in_ready, 0);
      lat_cfg = 2;
      rdy_rand = 1'b1;
      drain(2000);
      rdy_rand = 1'b0;

      // Consumer stall: no issue while a result is held
      lat_cfg = 3;
      rdy_fix = 1'b0;
      for (int i = 0; i < 3; i++) push($urandom, $urandom, 1'b0);
      n = 0;
      while (!out_valid && n < 200) begin
         cycles(1);
         n++;
      end
      chk("stall_first_valid", out_valid, 1);
      s0 = n_starts;
      cycles(20);
      chk("stall_no_issue", n_starts - s0, 0);
      chk("stall_still_valid", out_valid, 1);
      rdy_fix = 1'b1;
      drain(500);

      // Stale done kept high past the new start
      slow_clear = 1'b1;
      lat_cfg = 4;
      for (int i = 0; i < 3; i++) push($urandom, $urandom, 1'b0);
      drain(500);
      lat_cfg = 0;
      for (int i = 0; i < 2; i++) push($urandom, $urandom, 1'b0);
      drain(500);
      slow_clear = 1'b0;

      // Randomized traffic
      rdy_rand = 1'b1;
      for (int i = 0; i < 30; i++) begin
         lat_cfg = $urandom_range(0, 6);
         slow_clear = 1'($urandom_range(0, 1));
         cycles($urandom_range(0, 3));
         push($urandom, $urandom, 1'b0);
      end
      drain(3000);
      rdy_rand = 1'b0;
      rdy_fix = 1'b1;
      slow_clear = 1'b0;

`ifdef FPADD_TIMEOUT_EN
      // Adder never answers: abort after TIMEOUT WAIT cycles, then recover
      hang = 1'b1;
      push($urandom, $urandom, 1'b1);
      drain(500);
      chk("timeout_latency", last_lat, TIMEOUT + 2);
      hang = 1'b0;
      lat_cfg = 3;
      push($urandom, $urandom, 1'b0);
      drain(500);
`endif

      // Reset while in WAIT with pairs queued
      lat_cfg = 100;
      for (int i = 0; i < 4; i++) push($urandom, $urandom, 1'b0);
      cycles(6);
      reset = 1'b1;
      exp_issue.delete();
      exp_res.delete();
      cycles(1);
      chk("flush_in_ready", in_ready, 1);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_add_start", add_start, 0);
      chk("flush_add_ab", {add_a, add_b}, 0);
      reset = 1'b0;
      s0 = n_starts;
      cycles(30);
      chk("flush_no_issue", n_starts - s0, 0);
      lat_cfg = 2;
      push($urandom, $urandom, 1'b0);
      drain(200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
